// File: rtl/up_counter_pkg.sv
// Shared definitions for the up_counter block: FSM state encoding and width.
package up_counter_pkg;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_IDLE  = 2'b00;
  localparam logic [ST_W-1:0] ST_RUN   = 2'b01;
  localparam logic [ST_W-1:0] ST_PAUSE = 2'b10;

  typedef enum logic [ST_W-1:0] {
    S_IDLE  = ST_IDLE,
    S_RUN   = ST_RUN,
    S_PAUSE = ST_PAUSE
  } state_e;

endpackage

// File: rtl/edge_rise_det.sv
// Rising-edge detector: one flop of history plus an AND gate.
// Input must already be synchronous to clk.
module edge_rise_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic in_d;

  // Next history value is simply the current input.
  always_comb begin
    in_d = in;
  end

  // History flop; cleared so a high input right after reset reads as an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in_d;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/up_counter.sv
// up_counter: counts rising edges of a divided-clock tick while in RUN,
// wraps modulo MAX_COUNT+1 with a one-cycle wrap pulse, and is controlled
// by start/stop/clear pulses through a 3-state FSM.
// Optional macro UP_COUNTER_LOAD_EN adds a load port (IDLE/PAUSE only).
module up_counter
  import up_counter_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MAX_COUNT = 9999
) (
  input  logic             up_counter_fsys,
  input  logic             up_counter_rst,
  input  logic             up_counter_tick,
  input  logic             up_counter_start,
  input  logic             up_counter_stop,
  input  logic             up_counter_clear,
`ifdef UP_COUNTER_LOAD_EN
  input  logic             up_counter_load,
  input  logic [WIDTH-1:0] up_counter_load_val,
`endif
  output logic [WIDTH-1:0] up_counter_count,
  output logic             up_counter_wrap,
  output logic             up_counter_running
);

  // A terminal count of 0 or one that does not fit in WIDTH bits is unusable.
  if (MAX_COUNT < 1 || 64'(MAX_COUNT) > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_cfg
    $error("up_counter: MAX_COUNT outside 1..2**WIDTH-1");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             running_q, running_d;
  logic             rise;

  edge_rise_det u_tick_edge (
    .clk  (up_counter_fsys),
    .rst  (up_counter_rst),
    .in   (up_counter_tick),
    .rise (rise)
  );

  // Next state and count: clear > load > stop > start > increment.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    wrap_d  = 1'b0;
    if (up_counter_clear) begin
      state_d = S_IDLE;
      count_d = '0;
    end
`ifdef UP_COUNTER_LOAD_EN
    else if (up_counter_load && state_q != S_RUN) begin
      count_d = (up_counter_load_val > MAX_C) ? MAX_C : up_counter_load_val;
    end
`endif
    else begin
      case (state_q)
        S_IDLE: begin
          if (!up_counter_stop && up_counter_start) state_d = S_RUN;
        end
        S_RUN: begin
          if (up_counter_stop) begin
            state_d = S_PAUSE;
          end else if (rise) begin
            if (count_q == MAX_C) begin
              count_d = '0;
              wrap_d  = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        S_PAUSE: begin
          // Tick edges seen here are dropped, not queued.
          if (!up_counter_stop && up_counter_start) state_d = S_RUN;
        end
        default: state_d = S_IDLE;
      endcase
    end
    running_d = (state_d == S_RUN);
  end

  // State, count and registered outputs.
  always_ff @(posedge up_counter_fsys or posedge up_counter_rst) begin
    if (up_counter_rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      running_q <= running_d;
    end
  end

  assign up_counter_count   = count_q;
  assign up_counter_wrap    = wrap_q;
  assign up_counter_running = running_q;

endmodule
